// File: rtl/fifo_burst_fill_ctrl_pkg.sv
// Shared types for the FIFO burst refill scheduler.
// FSM states and request-length field width.
package fifo_burst_fill_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    REQ,
    DATA
  } state_t;

  localparam int LEN_WIDTH = 8;

endpackage

// File: rtl/fifo_burst_fill_ctrl.sv
// Write-side refill scheduler: issues read bursts when the FIFO
// has room, writes returned beats, and walks linear frame addresses.
module fifo_burst_fill_ctrl
  import fifo_burst_fill_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = 28,
  parameter int DATA_WIDTH  = 64,
  parameter int LEVEL_WIDTH = 11,
  parameter int FIFO_DEPTH  = 1024,
  parameter int BURST_LEN   = 16,
  parameter int FRAME_BEATS = 230400,
  parameter int BASE_ADDR   = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   frame_start,
  input  logic [LEVEL_WIDTH-1:0] fifo_level,
  input  logic                   fifo_full,
  output logic                   fifo_wr_en,
  output logic [DATA_WIDTH-1:0]  fifo_wr_data,
  output logic                   req_valid,
  input  logic                   req_ready,
  output logic [ADDR_WIDTH-1:0]  req_addr,
  output logic [LEN_WIDTH-1:0]   req_len,
  input  logic                   rdat_valid,
  input  logic [DATA_WIDTH-1:0]  rdat,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   overflow_err
);

  localparam int REM_W = $clog2(FRAME_BEATS + 1);
  localparam int BL_W  = $clog2(BURST_LEN + 1);
  localparam int CW    = (REM_W > BL_W) ? REM_W : BL_W;
  localparam int LW    = LEVEL_WIDTH + 1;

  localparam logic [ADDR_WIDTH-1:0] BASE =
    ADDR_WIDTH'(BASE_ADDR);
  localparam logic [REM_W-1:0] FRAME =
    REM_W'(FRAME_BEATS);

  state_t state, state_n;

  logic [ADDR_WIDTH-1:0] addr;
  logic [REM_W-1:0]      remaining;
  logic [CW-1:0]         beat_cnt;
  logic [CW-1:0]         cur_len;
  logic                  restart_pend;
  logic [LW-1:0]         lvl;
  logic [LW-1:0]         depth;
  logic                  room;
  logic                  beat;
  logic                  last_beat;
  logic                  frame_end;
  logic                  restart;

  assign cur_len = (CW'(remaining) < CW'(BURST_LEN))
                 ? CW'(remaining) : CW'(BURST_LEN);

  // Level above depth means no room rather than a wrapped difference.
  assign lvl   = {1'b0, fifo_level};
  assign depth = LW'(FIFO_DEPTH);
  assign room  = (lvl <= depth)
              && ((depth - lvl) >= LW'(cur_len));

  assign beat      = (state == DATA) && rdat_valid;
  assign last_beat = beat
                  && (beat_cnt == cur_len - 1'b1);
  assign frame_end = CW'(remaining) == cur_len;
  assign restart   = restart_pend || frame_start;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (enable) state_n = CHECK;
      CHECK: begin
        if (!enable)
          state_n = IDLE;
        else if (!frame_start && room)
          state_n = REQ;
      end
      REQ:   if (req_ready) state_n = DATA;
      DATA: begin
        if (last_beat)
          state_n = enable ? CHECK : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      addr         <= BASE;
      remaining    <= FRAME;
      beat_cnt     <= '0;
      restart_pend <= 1'b0;
      overflow_err <= 1'b0;
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= '0;
      frame_done   <= 1'b0;
    end else begin
      state      <= state_n;
      fifo_wr_en <= 1'b0;
      frame_done <= 1'b0;

      if (frame_start) begin
        if (state == IDLE || state == CHECK) begin
          addr         <= BASE;
          remaining    <= FRAME;
          overflow_err <= 1'b0;
        end else begin
          restart_pend <= 1'b1;
        end
      end

      if (state == REQ && req_ready)
        beat_cnt <= '0;

      if (beat) begin
        beat_cnt     <= beat_cnt + 1'b1;
        fifo_wr_data <= rdat;
        if (fifo_full)
          overflow_err <= 1'b1;
        else
          fifo_wr_en <= 1'b1;
      end

      // A pending or coincident restart wins over frame completion.
      if (last_beat) begin
        restart_pend <= 1'b0;
        if (restart) begin
          addr         <= BASE;
          remaining    <= FRAME;
          overflow_err <= fifo_full;
        end else if (frame_end) begin
          frame_done <= 1'b1;
          addr       <= BASE;
          remaining  <= FRAME;
        end else begin
          addr      <= addr + ADDR_WIDTH'(cur_len);
          remaining <= remaining - REM_W'(cur_len);
        end
      end
    end
  end

  assign req_valid = (state == REQ);
  assign req_addr  = req_valid ? addr : '0;
  assign req_len   = req_valid
                   ? LEN_WIDTH'(cur_len - 1'b1) : '0;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_fifo_burst_fill_ctrl.sv
// Randomized scoreboard bench for fifo_burst_fill_ctrl.
// Frame accounting is modelled with plain address/remaining arithmetic.
module tb_fifo_burst_fill_ctrl;

  localparam int AW    = 28;
  localparam int DW    = 64;
  localparam int LW    = 11;
  localparam int DEPTH = 1024;
  localparam int BL    = 16;
  localparam int FB    = 40;

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic          frame_start;
  logic [LW-1:0] fifo_level;
  logic          fifo_full;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_wr_data;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [7:0]    req_len;
  logic          rdat_valid;
  logic [DW-1:0] rdat;
  logic          busy;
  logic          frame_done;
  logic          overflow_err;

  fifo_burst_fill_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .LEVEL_WIDTH(LW),
    .FIFO_DEPTH (DEPTH),
    .BURST_LEN  (BL),
    .FRAME_BEATS(FB),
    .BASE_ADDR  (0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .frame_start (frame_start),
    .fifo_level  (fifo_level),
    .fifo_full   (fifo_full),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_wr_data(fifo_wr_data),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_len     (req_len),
    .rdat_valid  (rdat_valid),
    .rdat        (rdat),
    .busy        (busy),
    .frame_done  (frame_done),
    .overflow_err(overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int fd_cnt = 0;
  int exp_fd = 0;
  int m_addr;
  int m_rem;
  logic [DW-1:0] exp_wr[$];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [DW-1:0] e;
    if (rst_n && frame_done) fd_cnt++;
    if (rst_n && fifo_wr_en) begin
      if (exp_wr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_unexpected: got %0h expected none",
                 fifo_wr_data);
      end else begin
        e = exp_wr.pop_front();
        chk("wr_data", fifo_wr_data, e);
      end
    end
  end

  function automatic int next_len();
    return (m_rem < BL) ? m_rem : BL;
  endfunction

  task automatic do_burst(input int stall,
                          input int full_b,
                          input int fs_b,
                          input int en_b);
    int t;
    int len;
    int gap;
    logic [DW-1:0] d;
    len = next_len();
    t = 0;
    while (!req_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!req_valid) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: got none expected req at %0h",
               m_addr);
      return;
    end
    chk("req_addr", req_addr, m_addr);
    chk("req_len", req_len, len - 1);
    chk("frame_done_cnt", fd_cnt, exp_fd);
    req_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_valid", req_valid, 1);
      chk("stall_addr", req_addr, m_addr);
      chk("stall_len", req_len, len - 1);
    end
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    chk("req_drop", req_valid, 0);
    for (int b = 0; b < len; b++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      d = {$urandom, $urandom};
      rdat_valid  = 1'b1;
      rdat        = d;
      fifo_full   = (b == full_b);
      frame_start = (b == fs_b);
      if (b == en_b) enable = 1'b0;
      if (b != full_b) exp_wr.push_back(d);
      @(negedge clk);
      rdat_valid  = 1'b0;
      fifo_full   = 1'b0;
      frame_start = 1'b0;
    end
    if (fs_b >= 0) begin
      m_addr = 0;
      m_rem  = FB;
    end else begin
      m_addr += len;
      m_rem  -= len;
      if (m_rem == 0) begin
        exp_fd++;
        m_addr = 0;
        m_rem  = FB;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    int fb;
    int fsb;
    rst_n       = 1'b0;
    enable      = 1'b0;
    frame_start = 1'b0;
    fifo_level  = '0;
    fifo_full   = 1'b0;
    req_ready   = 1'b0;
    rdat_valid  = 1'b0;
    rdat        = '0;
    m_addr      = 0;
    m_rem       = FB;

    repeat (3) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_wr_data", fifo_wr_data, 0);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_req_addr", req_addr, 0);
    chk("rst_req_len", req_len, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_ovf", overflow_err, 0);

    rst_n = 1'b1;
    for (int i = 0; i < 2 && !req_valid; i++)
      @(negedge clk);
    chk("req_within_2", req_valid, 1);
    do_burst(0, -1, -1, -1);

    fifo_level  = LW'(1009);
    rdat_valid  = 1'b1;
    rdat        = {$urandom, $urandom};
    @(negedge clk);
    rdat_valid  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_req_free15", req_valid, 0);
    end
    fifo_level = LW'(1008);
    do_burst(0, -1, -1, -1);

    fifo_level = LW'(1017);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_req_free7", req_valid, 0);
    end
    fifo_level = LW'(1016);
    do_burst(0, -1, -1, -1);
    fifo_level = '0;

    do_burst(5, -1, -1, -1);

    do_burst(0, 3, -1, 2);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_req", req_valid, 0);
    chk("ovf_set", overflow_err, 1);
    repeat (3) @(negedge clk);
    chk("ovf_sticky", overflow_err, 1);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    chk("ovf_clear", overflow_err, 0);
    m_addr = 0;
    m_rem  = FB;
    enable = 1'b1;

    do_burst(0, -1, -1, -1);
    do_burst(0, -1, 8, -1);
    do_burst(1, -1, -1, -1);
    do_burst(0, -1, 15, -1);
    do_burst(2, -1, -1, -1);

    for (int n = 0; n < 30; n++) begin
      len = next_len();
      fifo_level = LW'($urandom_range(0, DEPTH - len));
      fb  = ($urandom_range(0, 7) == 0)
          ? $urandom_range(0, len - 1) : -1;
      fsb = ($urandom_range(0, 9) == 0)
          ? $urandom_range(0, len - 1) : -1;
      do_burst($urandom_range(0, 3), fb, fsb, -1);
    end

    repeat (4) @(negedge clk);
    chk("frame_done_final", fd_cnt, exp_fd);
    chk("wr_queue_empty", exp_wr.size(), 0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
